// File: rtl/div_unit.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed (DIV) or unsigned (DIVU).
// Quotient and remainder are registered and qualified by a one-cycle done pulse.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StFinish, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              div_zero_q, div_zero_d;

  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    shifted, diff;

  assign a_mag = (signed_op && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_mag = (signed_op && B[WIDTH-1]) ? (~B + 1'b1) : B;

  // One extra bit so a set top bit of diff means the trial subtraction borrowed.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          if (B == '0) begin
            quotient_d  = '1;
            remainder_d = A;
            div_zero_d  = 1'b1;
            state_d     = StDone;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            q_neg_d = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_d = signed_op & A[WIDTH-1];
            cnt_d   = CntW'(WIDTH);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        // Most-negative / -1 falls out naturally: magnitude 2^(W-1) negates to itself.
        quotient_d  = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        div_zero_d  = 1'b0;
        state_d     = StDone;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StBusy) || (state_d == StFinish);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: result table plus hand-written sequences for
// busy-time start, back-to-back start in DONE, and reset mid-operation.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] A, B;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .signed_op(signed_op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request at a negedge and count edges (including the sampling edge) until done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat);
    @(negedge clk);
    A = a; B = b; signed_op = s; start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      A = $urandom; B = $urandom; signed_op = 1'($urandom);
      lat++;
    end while (!done && lat < 100);
  endtask

  initial begin
    int lat;
    int done_seen;

    vecs[0]  = '{32'd100,      32'd20,       1'b0, 32'd5,        32'd0,        1'b0, 34};
    vecs[1]  = '{32'd100,      32'd0,        1'b0, 32'hFFFFFFFF, 32'd100,      1'b1, 1};
    vecs[2]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
    vecs[3]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
    vecs[4]  = '{32'hFFFFFFFF, 32'd16,       1'b0, 32'h0FFFFFFF, 32'd15,       1'b0, 34};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 34};
    vecs[6]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,        32'hFFFFFFFF, 1'b0, 34};
    vecs[7]  = '{32'd3,        32'd10,       1'b0, 32'd0,        32'd3,        1'b0, 34};
    vecs[8]  = '{32'hFFFFFFFD, 32'd10,       1'b1, 32'd0,        32'hFFFFFFFD, 1'b0, 34};
    vecs[9]  = '{32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0,        1'b0, 34};
    vecs[11] = '{32'hFFFFFFF9, 32'd2,        1'b0, 32'h7FFFFFFC, 32'd1,        1'b0, 34};
    vecs[12] = '{32'd30,       32'd4,        1'b0, 32'd7,        32'd2,        1'b0, 34};
    vecs[13] = '{32'h80000000, 32'd1,        1'b1, 32'h80000000, 32'd0,        1'b0, 34};
    vecs[14] = '{32'd1000,     32'd7,        1'b0, 32'd142,      32'd6,        1'b0, 34};

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d_div_zero", i), 32'(div_zero), 32'(vecs[i].dz));
      check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // start while busy is ignored
    @(negedge clk);
    A = 32'd100; B = 32'd20; signed_op = 1'b0; start = 1'b1;
    lat = 0;
    @(posedge clk); #1; start = 1'b0; lat++;
    repeat (4) begin @(posedge clk); #1; lat++; end
    check("busy_mid_op", 32'(busy), 32'd1);
    check("outputs_held_mid_op", quotient, 32'd142);
    @(negedge clk);
    A = 32'd7; B = 32'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lat++;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("ignored_start_latency", 32'(lat), 32'd34);
    check("ignored_start_quotient", quotient, 32'd5);
    check("ignored_start_div_zero", 32'(div_zero), 32'd0);

    // back-to-back: start driven during the done cycle
    A = 32'd30; B = 32'd4; signed_op = 1'b0; start = 1'b1;
    lat = 0;
    @(posedge clk); #1; start = 1'b0; lat++;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_outputs_held", quotient, 32'd5);
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("b2b_latency", 32'(lat), 32'd34);
    check("b2b_quotient", quotient, 32'd7);
    check("b2b_remainder", remainder, 32'd2);

    // reset mid-operation aborts with no done pulse
    @(negedge clk);
    A = 32'd1000; B = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_div_zero", 32'(div_zero), 32'd0);
    run_op(32'd30, 32'd4, 1'b0, lat);
    check("post_abort_latency", 32'(lat), 32'd34);
    check("post_abort_quotient", quotient, 32'd7);
    check("post_abort_remainder", remainder, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
